// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and sizes for the 16-way round-robin arbiter
package rr_arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_dec16.sv
// rtl/onehot_dec16.sv - 4-to-16 one-hot decoder with enable
module onehot_dec16
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - 16-requester round-robin arbiter, break-before-make, hold timeout
module rr_arbiter_16
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             pre_q, pre_d;
  logic [IDX_W-1:0] winner;
  logic             others_pending;
  logic             timeout;

  // First set request scanning upward from p, wrapping through 15 -> 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] c;
    logic             found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      c = p + IDX_W'(k);
      if (!found && r[c]) begin
        w     = c;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_idx   = idx_q;
  assign preempt   = pre_q;

  onehot_dec16 u_dec (
    .idx    (idx_q),
    .en     (gnt_valid),
    .onehot (gnt_onehot)
  );

  assign winner         = rr_pick(req, ptr_q);
  assign others_pending = |(req & ~gnt_onehot);
  // Once the hold limit is reached it stays armed (counter saturates) until someone else asks.
  assign timeout        = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST) && others_pending;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && |req) begin
          state_d = ST_GRANT;
          idx_d   = winner;
          ptr_d   = winner + 1'b1;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q] || !en || timeout) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          hold_d  = '0;
          pre_d   = req[idx_q] && en;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb/tb_rr_arbiter_16.sv - directed vector table plus timeout and random overlap/fairness sequences
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] req = '0;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt_onehot;
  logic        preempt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_16 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .preempt    (preempt)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic        valid;
    logic [3:0]  idx;
    logic        pre;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [15:0] rq,
                     input logic ev, input logic [3:0] ei, input logic ep);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = rq; v.valid = ev; v.idx = ei; v.pre = ep;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic r, input logic e, input logic [15:0] rq,
                       input logic ev, input logic [3:0] ei, input logic ep, input string nm);
    logic [15:0] eoh;
    rst_n = r; en = e; req = rq;
    @(posedge clk);
    #1;
    eoh = '0;
    if (ev) eoh[ei] = 1'b1;
    n_checks++;
    if (gnt_valid !== ev || gnt_idx !== ei || gnt_onehot !== eoh || preempt !== ep) begin
      n_errors++;
      $display("FAIL %s: got valid=%0b idx=%0d onehot=%h preempt=%0b, expected valid=%0b idx=%0d onehot=%h preempt=%0b",
               nm, gnt_valid, gnt_idx, gnt_onehot, preempt, ev, ei, eoh, ep);
    end
  endtask

  logic [15:0] rq_r;
  logic [15:0] prev_req;
  logic        prev_valid;
  logic [15:0] exp_oh;
  int          wait_cnt[16];
  int          worst;

  initial begin
    // reset held with everyone requesting, then first grant goes to 0
    add(0, 1, 16'hFFFF, 0, 0, 0);
    add(0, 1, 16'hFFFF, 0, 0, 0);
    add(1, 1, 16'hFFFF, 1, 0, 0);
    add(1, 1, 16'hFFFE, 0, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 0);
    add(0, 1, 16'h0000, 0, 0, 0);
    // rotation between 0 and 15 with one idle cycle between grants
    add(1, 1, 16'h8001, 1, 0, 0);
    add(1, 1, 16'h8001, 1, 0, 0);
    add(1, 1, 16'h8000, 0, 0, 0);
    add(1, 1, 16'h8001, 1, 15, 0);
    add(1, 1, 16'h8001, 1, 15, 0);
    add(1, 1, 16'h0001, 0, 0, 0);
    add(1, 1, 16'h8001, 1, 0, 0);
    add(1, 1, 16'h8001, 1, 0, 0);
    add(1, 1, 16'h8000, 0, 0, 0);
    add(1, 1, 16'h8001, 1, 15, 0);
    add(1, 1, 16'h8001, 1, 15, 0);
    add(1, 1, 16'h0001, 0, 0, 0);
    add(0, 1, 16'h0000, 0, 0, 0);
    // pointer wrap from 15
    add(1, 1, 16'h4000, 1, 14, 0);
    add(1, 1, 16'h0000, 0, 0, 0);
    add(1, 1, 16'h4003, 1, 0, 0);
    add(1, 1, 16'h4002, 0, 0, 0);
    add(1, 1, 16'h4003, 1, 1, 0);
    add(1, 1, 16'h4001, 0, 0, 0);
    add(1, 1, 16'h4003, 1, 14, 0);
    add(1, 1, 16'h0003, 0, 0, 0);
    add(0, 1, 16'h0000, 0, 0, 0);
    // enable drop mid-grant, and no grant while disabled
    add(1, 1, 16'h0080, 1, 7, 0);
    add(1, 0, 16'h0080, 0, 0, 0);
    add(1, 0, 16'h0080, 0, 0, 0);
    add(1, 0, 16'hFFFF, 0, 0, 0);
    add(1, 1, 16'h0080, 1, 7, 0);
    add(0, 1, 16'h0080, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].valid, vecs[i].idx, vecs[i].pre,
            $sformatf("vec%0d", i));

    // timeout: 3 holds, 5 joins on grant cycle 2, preempt after 8 grant cycles
    apply(1, 1, 16'h0008, 1, 3, 0, "to_grant3");
    for (int k = 0; k < 7; k++) apply(1, 1, 16'h0028, 1, 3, 0, $sformatf("to_hold%0d", k));
    apply(1, 1, 16'h0028, 0, 0, 1, "to_preempt");
    apply(1, 1, 16'h0028, 1, 5, 0, "to_grant5");
    apply(1, 1, 16'h0008, 0, 0, 0, "to_rel5");
    apply(1, 1, 16'h0008, 1, 3, 0, "alone_grant3");
    for (int k = 0; k < 30; k++) apply(1, 1, 16'h0008, 1, 3, 0, $sformatf("alone_hold%0d", k));
    apply(1, 1, 16'h0028, 0, 0, 1, "late_preempt");
    apply(1, 1, 16'h0028, 1, 5, 0, "late_grant5");
    for (int k = 0; k < 7; k++) apply(1, 1, 16'h0028, 1, 5, 0, $sformatf("prec_a_hold%0d", k));
    apply(1, 1, 16'h0008, 0, 0, 0, "release_beats_timeout");
    apply(1, 1, 16'h0008, 1, 3, 0, "prec_b_grant3");
    for (int k = 0; k < 7; k++) apply(1, 1, 16'h0028, 1, 3, 0, $sformatf("prec_b_hold%0d", k));
    apply(1, 0, 16'h0028, 0, 0, 0, "enable_beats_timeout");

    // random traffic: overlap, decode consistency, fairness
    apply(0, 0, 16'h0000, 0, 0, 0, "rand_reset");
    rst_n = 1'b1;
    rq_r = '0;
    prev_valid = 1'b0;
    for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 16; b++)
        if ($urandom_range(0, 5) == 0) rq_r[b] = ~rq_r[b];
      prev_req = rq_r;
      req = rq_r;
      en = ($urandom_range(0, 15) != 0);
      @(posedge clk);
      #1;
      exp_oh = '0;
      if (gnt_valid) exp_oh[gnt_idx] = 1'b1;
      n_checks++;
      if ($countones(gnt_onehot) > 1 || gnt_onehot !== exp_oh || (!gnt_valid && gnt_idx !== 4'd0)) begin
        n_errors++;
        $display("FAIL rand_onehot cycle %0d: got onehot=%h valid=%0b idx=%0d, expected onehot=%h",
                 n, gnt_onehot, gnt_valid, gnt_idx, exp_oh);
      end
      for (int i = 0; i < 16; i++)
        if (!prev_req[i]) wait_cnt[i] = 0;
      if (gnt_valid && !prev_valid) begin
        worst = 0;
        for (int i = 0; i < 16; i++) begin
          if (prev_req[i]) begin
            if (i == int'(gnt_idx)) wait_cnt[i] = 0;
            else wait_cnt[i]++;
          end
          if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        n_checks++;
        if (worst > 15 || !prev_req[gnt_idx]) begin
          n_errors++;
          $display("FAIL rand_fair cycle %0d: got worst wait=%0d winner requesting=%0b, expected wait<=15 requesting=1",
                   n, worst, prev_req[gnt_idx]);
        end
      end
      prev_valid = gnt_valid;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
